// File: rtl/trigger_dispatch_pkg.sv
// Shared definitions for the trigger dispatcher: command codes, FSM states, frame length.
// Pure declarations; no latency or flow control of its own.
package trigger_dispatch_pkg;

  localparam int TRG     = 0;
  localparam int CAL     = 1;
  localparam int RES_ROC = 2;
  localparam int RES_TBM = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  // One start bit followed by the n-bit code.
  function automatic int frame_len(input int n);
    return n + 1;
  endfunction

endpackage

// File: rtl/trigger_dispatch_if.sv
// Trigger-side inputs and serial/status outputs of the dispatcher.
// master drives triggers and controls; slave is the dispatcher itself.
interface trigger_dispatch_if
  import trigger_dispatch_pkg::*;
#(
  parameter int N = 3
);
  logic         sync;
  logic         enable;
  logic [7:0]   spacing;
  logic         trg_in;
  logic [N-1:0] data_in;
  logic         cmd_out;
  logic         busy;
  logic [31:0]  trg_count;
  logic [15:0]  lost_count;

  modport master (
    output sync, enable, spacing, trg_in, data_in,
    input  cmd_out, busy, trg_count, lost_count
  );

  modport slave (
    input  sync, enable, spacing, trg_in, data_in,
    output cmd_out, busy, trg_count, lost_count
  );
endinterface

// File: rtl/trigger_dispatch_cmd_fifo.sv
// Pending command-code queue, DEPTH entries (power of 2), advanced only on sync cycles.
// Head visible on dout one sync after the write; push when full is ignored unless paired with pop.
module cmd_fifo #(
  parameter int N     = 3,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         sync,
  input  logic         push,
  input  logic         pop,
  input  logic [N-1:0] din,
  output logic [N-1:0] dout,
  output logic         empty,
  output logic         full
);
  localparam int AW = $clog2(DEPTH);

  logic [N-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  logic         push_ok;
  logic         pop_ok;

  assign pop_ok  = sync & pop & ~empty;
  assign push_ok = sync & push & (~full | pop_ok);

  // Extra pointer MSB distinguishes full from empty when the indices meet.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign dout  = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/trigger_dispatch.sv
// Queues qualified triggers and serialises each as start bit + code MSB-first on cmd_out, one bit per sync.
// Start bit appears one sync after the trigger; a full queue drops triggers and counts them in lost_count.
module trigger_dispatch
  import trigger_dispatch_pkg::*;
#(
  parameter int N     = 3,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset,
  trigger_dispatch_if.slave bus
);
  localparam int FRAME_LEN = frame_len(N);
  localparam int BW        = $clog2(FRAME_LEN);

  state_t       state;
  state_t       state_nxt;
  logic         trg_req;
  logic         pop_req;
  logic         fifo_push;
  logic         fifo_pop;
  logic         fifo_empty;
  logic         fifo_full;
  logic [N-1:0] fifo_dout;
  logic [N-1:0] shreg;
  logic [BW-1:0] bits_left;
  logic [7:0]   gap_cnt;
  logic         cmd_nxt;
  logic         cmd_q;
  logic         busy_q;
  logic [31:0]  trg_cnt_q;
  logic [15:0]  lost_cnt_q;

  assign trg_req   = bus.sync & bus.trg_in & bus.enable;
  assign fifo_pop  = bus.sync & pop_req;
  assign fifo_push = trg_req & (~fifo_full | fifo_pop);

  cmd_fifo #(
    .N     (N),
    .DEPTH (DEPTH)
  ) u_cmd_fifo (
    .clk   (clk),
    .reset (reset),
    .sync  (bus.sync),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (bus.data_in),
    .dout  (fifo_dout),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset)         state <= ST_IDLE;
    else if (bus.sync) state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    pop_req   = 1'b0;
    cmd_nxt   = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (!fifo_empty) begin
          pop_req   = 1'b1;
          cmd_nxt   = 1'b1;
          state_nxt = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        // bits_left counts code bits still to go after the one now on the line.
        if (bits_left == '0) state_nxt = (bus.spacing != 8'd0) ? ST_GAP : ST_IDLE;
        else                 cmd_nxt   = shreg[N-1];
      end
      ST_GAP: begin
        if (gap_cnt <= 8'd1) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cmd_q      <= 1'b0;
      busy_q     <= 1'b0;
      shreg      <= '0;
      bits_left  <= '0;
      gap_cnt    <= '0;
      trg_cnt_q  <= '0;
      lost_cnt_q <= '0;
    end else if (bus.sync) begin
      cmd_q  <= cmd_nxt;
      // A pop only happens on the way into SHIFT, so with IDLE next the queue can only grow.
      busy_q <= (state_nxt != ST_IDLE) || !fifo_empty || fifo_push;

      if (pop_req) begin
        shreg     <= fifo_dout;
        bits_left <= BW'(FRAME_LEN - 1);
        if (fifo_dout == N'(TRG)) trg_cnt_q <= trg_cnt_q + 32'd1;
      end else if (state == ST_SHIFT && bits_left != '0) begin
        shreg     <= shreg << 1;
        bits_left <= bits_left - BW'(1);
      end

      if (state == ST_SHIFT && state_nxt == ST_GAP) gap_cnt <= bus.spacing;
      else if (state == ST_GAP)                     gap_cnt <= gap_cnt - 8'd1;

      if (trg_req && fifo_full && !fifo_pop && lost_cnt_q != 16'hFFFF)
        lost_cnt_q <= lost_cnt_q + 16'd1;
    end
  end

  assign bus.cmd_out    = cmd_q;
  assign bus.busy       = busy_q;
  assign bus.trg_count  = trg_cnt_q;
  assign bus.lost_count = lost_cnt_q;

endmodule

// File: tb/tb_trigger_dispatch.sv
// Directed bench for trigger_dispatch: hand-scheduled frames, gaps, loss, enable and reset behaviour.
module tb_trigger_dispatch;
  import trigger_dispatch_pkg::*;

  localparam int N     = 3;
  localparam int DEPTH = 4;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  trigger_dispatch_if #(.N(N)) bus ();

  trigger_dispatch #(.N(N), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int tests    = 0;
  int fails    = 0;
  int sync_div = 1;
  int sdiv_cnt = 0;
  int codes[$];

  // One sync pulse every sync_div clocks, changed away from the active edge.
  always @(negedge clk) begin
    if (sdiv_cnt + 1 >= sync_div) begin
      bus.sync = 1'b1;
      sdiv_cnt = 0;
    end else begin
      bus.sync = 1'b0;
      sdiv_cnt++;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next sync edge; inputs set before the call apply at that edge.
  task automatic tick();
    do @(posedge clk); while (bus.sync !== 1'b1);
    #1;
  endtask

  // Expected cmd_out after sync edge t, frames of the codes queue starting at t=1 every period edges.
  function automatic logic exp_cmd(input int t, input int period);
    int r, f, p, c;
    if (t < 1) return 1'b0;
    r = t - 1;
    f = r / period;
    p = r % period;
    if (f >= codes.size()) return 1'b0;
    if (p == 0) return 1'b1;
    if (p <= N) begin
      c = codes[f];
      return c[N-p];
    end
    return 1'b0;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.enable  = 1'b0;
    bus.spacing = 8'd0;
    bus.trg_in  = 1'b0;
    bus.data_in = '0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_cmd_out", bus.cmd_out, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_trg_count", bus.trg_count, 0);
    check("rst_lost_count", bus.lost_count, 0);
    @(negedge clk);
    reset = 1'b0;

    // Single code 0, spacing 2, sync every 4th clk; spacing changed once the gap has started.
    sync_div = 4;
    tick(); tick();
    bus.enable  = 1'b1;
    bus.spacing = 8'd2;
    bus.trg_in  = 1'b1;
    bus.data_in = 3'(TRG);
    tick();
    bus.trg_in = 1'b0;
    check("s1_k_cmd", bus.cmd_out, 0);
    check("s1_k_busy", bus.busy, 1);
    tick();
    check("s1_start", bus.cmd_out, 1);
    check("s1_trg_count", bus.trg_count, 1);
    repeat (2) @(posedge clk);
    #1;
    check("s1_hold_between_syncs", bus.cmd_out, 1);
    tick(); check("s1_bit1", bus.cmd_out, 0);
    tick(); check("s1_bit2", bus.cmd_out, 0);
    tick(); check("s1_bit3", bus.cmd_out, 0);
    tick();
    check("s1_gap_cmd", bus.cmd_out, 0);
    check("s1_gap_busy", bus.busy, 1);
    bus.spacing = 8'd9;
    tick(); check("s1_gap2_busy", bus.busy, 1);
    tick();
    check("s1_idle_busy", bus.busy, 0);
    check("s1_idle_cmd", bus.cmd_out, 0);

    // Codes 5 and 3 on consecutive syncs, spacing 0: 1101, idle, 1011.
    sync_div    = 1;
    bus.spacing = 8'd0;
    tick(); tick();
    codes = '{5, 3};
    for (int t = 0; t <= 10; t++) begin
      bus.trg_in  = (t < 2);
      bus.data_in = (t == 0) ? 3'd5 : 3'd3;
      tick();
      check($sformatf("s2_cmd_t%0d", t), bus.cmd_out, exp_cmd(t, 5));
      check($sformatf("s2_busy_t%0d", t), bus.busy, (t < 10) ? 1 : 0);
    end
    check("s2_lost", bus.lost_count, 0);

    // Six triggers into a 4-deep queue, spacing 10: sixth (code 6) is lost.
    bus.spacing = 8'd10;
    codes = '{1, 2, 3, 4, 5};
    for (int t = 0; t <= 80; t++) begin
      bus.trg_in  = (t < 6);
      bus.data_in = 3'(t + 1);
      tick();
      check($sformatf("s3_cmd_t%0d", t), bus.cmd_out, exp_cmd(t, 15));
      if (t == 4) check("s3_lost_before", bus.lost_count, 0);
      if (t == 5) check("s3_lost_after", bus.lost_count, 1);
    end
    check("s3_busy_end", bus.busy, 0);
    check("s3_lost_end", bus.lost_count, 1);

    // Full queue with a pop on the same sync as a push: push accepted, no loss.
    bus.spacing = 8'd0;
    codes = '{7, 6, 5, 4, 3, TRG};
    for (int t = 0; t <= 32; t++) begin
      bus.trg_in  = (t < 5) || (t == 6);
      bus.data_in = (t < 5) ? 3'(7 - t) : 3'(TRG);
      tick();
      check($sformatf("s4_cmd_t%0d", t), bus.cmd_out, exp_cmd(t, 5));
      if (t == 6) check("s4_lost_on_pop", bus.lost_count, 1);
    end
    check("s4_busy_end", bus.busy, 0);
    check("s4_trg_count", bus.trg_count, 2);

    // Triggers while disabled are ignored.
    bus.enable  = 1'b0;
    bus.trg_in  = 1'b1;
    bus.data_in = 3'd2;
    for (int t = 0; t < 4; t++) begin
      tick();
      check($sformatf("s5a_cmd_t%0d", t), bus.cmd_out, 0);
      check($sformatf("s5a_busy_t%0d", t), bus.busy, 0);
    end

    // Enable dropped mid-frame: both queued frames still go out, later triggers do not.
    codes = '{5, 6};
    for (int t = 0; t <= 14; t++) begin
      bus.enable  = (t < 2);
      bus.trg_in  = (t < 5);
      bus.data_in = (t == 0) ? 3'd5 : (t == 1) ? 3'd6 : 3'd1;
      tick();
      check($sformatf("s5b_cmd_t%0d", t), bus.cmd_out, exp_cmd(t, 5));
    end
    check("s5b_busy_end", bus.busy, 0);
    check("s5b_lost", bus.lost_count, 1);
    check("s5b_trg_count", bus.trg_count, 2);

    // Reset during bit 2 of a frame with two more entries queued.
    sync_div   = 2;
    bus.trg_in = 1'b0;
    tick(); tick();
    bus.enable  = 1'b1;
    bus.trg_in  = 1'b1;
    bus.data_in = 3'd7;
    tick();
    bus.data_in = 3'd3;
    tick();
    bus.data_in = 3'd2;
    tick();
    bus.trg_in = 1'b0;
    tick();
    check("s6_pre_reset_cmd", bus.cmd_out, 1);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("s6_async_cmd", bus.cmd_out, 0);
    @(posedge clk);
    #1;
    check("s6_rst_cmd", bus.cmd_out, 0);
    check("s6_rst_busy", bus.busy, 0);
    check("s6_rst_trg_count", bus.trg_count, 0);
    check("s6_rst_lost_count", bus.lost_count, 0);
    @(negedge clk);
    reset = 1'b0;
    for (int t = 0; t < 12; t++) begin
      tick();
      check($sformatf("s6_post_cmd_t%0d", t), bus.cmd_out, 0);
      check($sformatf("s6_post_busy_t%0d", t), bus.busy, 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
